// File: rtl/vov_packer.sv
// Packs M consecutive K-bit vov words into one K*M-bit word and buffers it in a small FIFO.
// Optional out_parity port and parity storage are enabled with VOV_PACKER_PARITY_EN.
module vov_packer #(
    parameter int K     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [K-1:0]     vov_in,
    input  logic             vov_valid,
    input  logic             flush,
    output logic [K*M-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             overflow_clr,
`ifdef VOV_PACKER_PARITY_EN
    output logic             out_parity,
`endif
    output logic [2:0]       word_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [K*M-1:0] pack_q;
    logic [K*M-1:0] pack_next;
    logic [K*M-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           pack_done;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;

    // This cycle's word merged into the pack, so a completing pack includes it.
    always_comb begin
        pack_next = pack_q;
        pack_next[word_cnt*K +: K] = vov_in;
    end

    assign pack_done = vov_valid && !flush && (word_cnt == 3'(M-1));
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = pack_done && (!full || pop);
    assign drop      = pack_done && full && !pop;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q   <= '0;
            word_cnt <= '0;
        end else if (flush) begin
            word_cnt <= '0;
        end else if (vov_valid) begin
            pack_q   <= pack_next;
            word_cnt <= pack_done ? 3'd0 : word_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pack_next;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set dominates clear when a drop coincides with overflow_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

`ifdef VOV_PACKER_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
        end else if (push) begin
            par_mem[wr_ptr] <= ^pack_next;
        end
    end

    assign out_parity = par_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_vov_packer.sv
// Directed bench for vov_packer with K=4, M=2, DEPTH=2; parity checks run when VOV_PACKER_PARITY_EN is defined.
module tb_vov_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] vov_in;
    logic       vov_valid;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       overflow_clr;
    logic [2:0] word_cnt;
`ifdef VOV_PACKER_PARITY_EN
    logic       out_parity;
`endif

    int checks = 0;
    int errors = 0;

    vov_packer #(.K(4), .M(2), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vov_in       (vov_in),
        .vov_valid    (vov_valid),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
`ifdef VOV_PACKER_PARITY_EN
        .out_parity   (out_parity),
`endif
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [3:0] v);
        vov_valid = 1'b1;
        vov_in    = v;
        step();
        vov_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vov_in = '0; vov_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        step(); step();
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_data",  16'(out_data),  16'h0);
        chk("rst_wcnt",  16'(word_cnt),  16'h0);
        chk("rst_ovf",   16'(overflow),  16'h0);
        rst_n = 1'b1;
        step();

        // pack order
        out_ready = 1'b1;
        word(4'h3);
        chk("po_wcnt1",  16'(word_cnt),  16'h1);
        chk("po_valid0", 16'(out_valid), 16'h0);
        word(4'hA);
        chk("po_wcnt0",  16'(word_cnt),  16'h0);
        chk("po_valid1", 16'(out_valid), 16'h1);
        chk("po_data",   16'(out_data),  16'hA3);
`ifdef VOV_PACKER_PARITY_EN
        chk("par_a3",    16'(out_parity), 16'h0);
`endif
        step();
        chk("po_drained", 16'(out_valid), 16'h0);

        // gapped input
        word(4'h1);
        chk("gap_w1", 16'(word_cnt), 16'h1);
        step();
        chk("gap_w2", 16'(word_cnt), 16'h1);
        step();
        chk("gap_w3", 16'(word_cnt), 16'h1);
        word(4'h2);
        chk("gap_w4",    16'(word_cnt),  16'h0);
        chk("gap_valid", 16'(out_valid), 16'h1);
        chk("gap_data",  16'(out_data),  16'h21);
`ifdef VOV_PACKER_PARITY_EN
        chk("par_21",    16'(out_parity), 16'h0);
`endif
        step();
        chk("gap_drained", 16'(out_valid), 16'h0);

        // backpressure and overflow
        out_ready = 1'b0;
        word(4'h1); word(4'h2);
        chk("bp_head",  16'(out_data), 16'h21);
        word(4'h3); word(4'h4);
        chk("bp_noovf", 16'(overflow), 16'h0);
        word(4'h5); word(4'h6);
        chk("bp_ovf",   16'(overflow), 16'h1);
        chk("bp_wcnt",  16'(word_cnt), 16'h0);
        chk("bp_hold",  16'(out_data), 16'h21);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_valid", 16'(out_valid), 16'h1);
        chk("bp_pop1_data",  16'(out_data),  16'h43);
        step();
        chk("bp_empty",  16'(out_valid), 16'h0);
        chk("bp_sticky", 16'(overflow),  16'h1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("bp_clr", 16'(overflow), 16'h0);

        // full FIFO with a simultaneous pop
        out_ready = 1'b0;
        word(4'h1); word(4'h2); word(4'h3); word(4'h4);
        word(4'h5);
        out_ready = 1'b1;
        word(4'h6);
        chk("fp_noovf", 16'(overflow),  16'h0);
        chk("fp_data1", 16'(out_data),  16'h43);
        step();
        chk("fp_valid2", 16'(out_valid), 16'h1);
        chk("fp_data2",  16'(out_data),  16'h65);
        step();
        chk("fp_empty", 16'(out_valid), 16'h0);

        // flush
        word(4'h7);
        chk("fl_wcnt1", 16'(word_cnt), 16'h1);
        flush = 1'b1;
        word(4'h9);
        flush = 1'b0;
        chk("fl_wcnt0", 16'(word_cnt),  16'h0);
        chk("fl_valid", 16'(out_valid), 16'h0);
        word(4'h5);
        chk("fl_wcnt_re", 16'(word_cnt), 16'h1);
        word(4'h6);
        chk("fl_data", 16'(out_data), 16'h65);
        step();
        chk("fl_empty", 16'(out_valid), 16'h0);

        // overflow set wins over a same-cycle clear
        out_ready = 1'b0;
        word(4'h1); word(4'h2); word(4'h3); word(4'h4); word(4'h5);
        overflow_clr = 1'b1;
        word(4'h6);
        overflow_clr = 1'b0;
        chk("setwin_ovf",  16'(overflow), 16'h1);
        chk("setwin_head", 16'(out_data), 16'h21);

        // reset mid-operation: one FIFO entry, word_cnt=1, overflow set
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mr_one_entry", 16'(out_data), 16'h43);
        word(4'h7);
        chk("mr_wcnt1", 16'(word_cnt), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 16'(out_valid), 16'h0);
        chk("mr_wcnt",  16'(word_cnt),  16'h0);
        chk("mr_ovf",   16'(overflow),  16'h0);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        word(4'h3); word(4'hA);
        chk("mr_resume_valid", 16'(out_valid), 16'h1);
        chk("mr_resume_data",  16'(out_data),  16'hA3);
        step();
`ifdef VOV_PACKER_PARITY_EN
        word(4'h1); word(4'h0);
        chk("par_01_data", 16'(out_data),   16'h01);
        chk("par_01",      16'(out_parity), 16'h1);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
